// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult sequential multiplier.
// Contents: FSM state enum, default operand width, absolute-value helper.
package seq_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  // Widest operand the abs helper supports; callers sign-extend into it.
  localparam int unsigned ABS_MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's complement magnitude of a sign-extended operand. Callers truncate
  // the result to their width; the most negative value maps to 2^(W-1).
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] x);
    return x[ABS_MAX_W-1] ? (~x + ABS_MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath for seq_mult: accumulator, operand magnitudes, step
// counter and the final sign fix-up into the product register.
// Ports: load_i (capture operands), step_i (process one multiplier bit),
//   a_i/b_i/signed_mode_i operands, last_c (this step completes the
//   operation, combinational), product_o (registered result).
// Config: SEQ_MULT_EARLY_TERM_EN ends the operation once no multiplier
//   bits remain.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_mode_i,
  output logic               last_c,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // Operand magnitudes for signed mode.
  assign a_mag = WIDTH'(abs_w(ABS_MAX_W'($signed(a_i))));
  assign b_mag = WIDTH'(abs_w(ABS_MAX_W'($signed(b_i))));

  // Partial product for the current step, including this step's add.
  assign addend  = mb_q[0] ? ({WIDTH'(0), ma_q} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_c = (cnt_q == CNT_W'(WIDTH - 1)) || ((mb_q >> 1) == '0);
`else
  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Next-state for load, step and final product capture.
  always_comb begin
    acc_d     = acc_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load_i) begin
      acc_d = '0;
      cnt_d = '0;
      ma_d  = signed_mode_i ? a_mag : a_i;
      mb_d  = signed_mode_i ? b_mag : b_i;
      neg_d = signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      acc_d = acc_sum;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_c) begin
        product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with valid/ready on input and output.
// One operation in flight; product held under unbounded backpressure.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b,
//   signed_mode (input side); out_valid/out_ready, product (output side);
//   busy (high while multiplier bits are being processed).
// Config: define SEQ_MULT_EARLY_TERM_EN for data-dependent latency.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_e state_q, state_d;
  logic   load_c, step_c, last_c;
  logic   in_ready_q, out_valid_q, busy_q;

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load_c),
    .step_i        (step_c),
    .a_i           (a),
    .b_i           (b),
    .signed_mode_i (signed_mode),
    .last_c        (last_c),
    .product_o     (product)
  );

  // Next-state and datapath controls.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_c  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step_c = 1'b1;
        if (last_c) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == BUSY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (WIDTH=8) plus a WIDTH=16 reference-model run.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        in_valid_w, in_ready_w, signed_mode_w, out_valid_w, out_ready_w, busy_w;
  logic [15:0] a_w, b_w;
  logic [31:0] product_w;

  int checks = 0;
  int passed = 0;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam int LAT_B1  = 1;
  localparam int LAT_B10 = 5;
`else
  localparam int LAT_B1  = 8;
  localparam int LAT_B10 = 8;
`endif

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .signed_mode(signed_mode_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .product(product_w), .busy(busy_w)
  );

  // Start an op from IDLE (called at posedge+1) and wait for out_valid.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                         output logic [15:0] res, output int lat, output int busy_n);
    a = ta; b = tb; signed_mode = tsm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    res = product;
  endtask

  task automatic release8();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (product !== 16'h0) $display("FAIL reset_product got=%h exp=0000", product); else passed++;
  endtask

  task automatic test_unsigned_max();
    logic [15:0] res; int lat, bn;
    run_op8(8'hFF, 8'hFF, 1'b0, res, lat, bn);
    checks++; if (res !== 16'hFE01) $display("FAIL umax_product got=%h exp=fe01", res); else passed++;
    checks++; if (lat !== 8) $display("FAIL umax_latency got=%0d exp=8", lat); else passed++;
    checks++; if (bn !== 8) $display("FAIL umax_busy_cycles got=%0d exp=8", bn); else passed++;
    release8();
    checks++; if (out_valid !== 1'b0) $display("FAIL umax_out_valid_drop got=%b exp=0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL umax_in_ready_rise got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_signed();
    logic [7:0]  va [4] = '{8'hFD, 8'h80, 8'h00, 8'h05};
    logic [7:0]  vb [4] = '{8'h05, 8'h80, 8'hF9, 8'hFD};
    logic [15:0] ve [4] = '{16'hFFF1, 16'h4000, 16'h0000, 16'hFFF1};
    logic [15:0] res; int lat, bn;
    for (int i = 0; i < 4; i++) begin
      run_op8(va[i], vb[i], 1'b1, res, lat, bn);
      checks++;
      if (res !== ve[i]) $display("FAIL signed_%0d got=%h exp=%h", i, res, ve[i]); else passed++;
      release8();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res; int lat, bn;
    run_op8(8'd12, 8'd10, 1'b0, res, lat, bn);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'd3; b = 8'd3;
      @(posedge clk); #1;
      checks++;
      if (product !== 16'h0078 || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold_%0d got prod=%h in_ready=%b out_valid=%b exp prod=0078 in_ready=0 out_valid=1",
                 i, product, in_ready, out_valid);
      else passed++;
    end
    in_valid = 1'b0;
    release8();
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); else passed++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL bp_ignored_in_valid busy=%b exp=0", busy); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] res; int lat, bn;
    a = 8'd9; b = 8'd9; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0)
      $display("FAIL midreset got in_ready=%b out_valid=%b busy=%b prod=%h exp 1 0 0 0000",
               in_ready, out_valid, busy, product);
    else passed++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op8(8'd7, 8'd6, 1'b0, res, lat, bn);
    checks++; if (res !== 16'h002A) $display("FAIL midreset_next got=%h exp=002a", res); else passed++;
    release8();
  endtask

  task automatic test_early_term();
    logic [15:0] res; int lat, bn;
    run_op8(8'd200, 8'd1, 1'b0, res, lat, bn);
    checks++; if (res !== 16'h00C8) $display("FAIL et_b1_product got=%h exp=00c8", res); else passed++;
    checks++; if (lat !== LAT_B1) $display("FAIL et_b1_latency got=%0d exp=%0d", lat, LAT_B1); else passed++;
    release8();
    run_op8(8'd200, 8'h10, 1'b0, res, lat, bn);
    checks++; if (res !== 16'h0C80) $display("FAIL et_b10_product got=%h exp=0c80", res); else passed++;
    checks++; if (lat !== LAT_B10) $display("FAIL et_b10_latency got=%0d exp=%0d", lat, LAT_B10); else passed++;
    release8();
  endtask

  task automatic test_w16_regression();
    logic [15:0] ta, tb; logic tsm; longint ra, rb; logic [31:0] exp; int lat;
    for (int i = 0; i < 300; i++) begin
      ta = 16'($urandom); tb = 16'($urandom); tsm = 1'($urandom_range(0, 1));
      if (i == 0) begin ta = 16'h8000; tb = 16'h8000; tsm = 1'b1; end
      if (i == 1) begin ta = 16'h0000; tb = 16'hFFF9; tsm = 1'b1; end
      ra = tsm ? longint'($signed(ta)) : longint'(ta);
      rb = tsm ? longint'($signed(tb)) : longint'(tb);
      exp = 32'(ra * rb);
      a_w = ta; b_w = tb; signed_mode_w = tsm; in_valid_w = 1'b1;
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      lat = 0;
      while (!out_valid_w && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      checks++;
      if (!out_valid_w || product_w !== exp)
        $display("FAIL w16_%0d a=%h b=%h s=%b got=%h valid=%b exp=%h",
                 i, ta, tb, tsm, product_w, out_valid_w, exp);
      else passed++;
      out_ready_w = 1'b1;
      @(posedge clk); #1;
      out_ready_w = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
    in_valid_w = 1'b0; a_w = '0; b_w = '0; signed_mode_w = 1'b0; out_ready_w = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_unsigned_max();
    test_signed();
    test_backpressure();
    test_reset_mid_op();
    test_early_term();
    test_w16_regression();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
